// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin front end that sequences one AXI-lite read or write at a time
// on the master port and returns the response to the granted requester.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  // Requester 0 (instruction fetch)
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_W-1:0]     r0_addr,
  input  logic [DATA_W-1:0]     r0_wdata,
  input  logic [DATA_W/8-1:0]   r0_wstrb,
  output logic                  r0_done,
  output logic [DATA_W-1:0]     r0_rdata,
  output logic                  r0_err,
  // Requester 1 (data load/store)
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_W-1:0]     r1_addr,
  input  logic [DATA_W-1:0]     r1_wdata,
  input  logic [DATA_W/8-1:0]   r1_wstrb,
  output logic                  r1_done,
  output logic [DATA_W-1:0]     r1_rdata,
  output logic                  r1_err,
  // AXI-lite master
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  // Status
  output logic                  busy,
  output logic                  grant_id
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StB, StDone} state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                win;
  logic                win_we;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic                rsp_load;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    win       = 1'b0;
    win_we    = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    rsp_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (r0_req || r1_req) begin
          // On a tie the requester that did not win last time goes first.
          win       = (r0_req && r1_req) ? ~ptr_q : r1_req;
          win_we    = win ? r1_we : r0_we;
          ptr_d     = win;
          gnt_d     = win;
          addr_d    = win ? r1_addr : r0_addr;
          wdata_d   = win ? r1_wdata : r0_wdata;
          wstrb_d   = win ? r1_wstrb : r0_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = win_we ? StAw : StAr;
        end
      end
      StAr: begin
        if (m_arready) state_d = StR;
      end
      StR: begin
        if (m_rvalid) begin
          rsp_data = m_rdata;
          rsp_err  = (m_rresp != 2'b00);
          rsp_load = 1'b1;
          state_d  = StDone;
        end
      end
      StAw: begin
        if (m_awready) aw_done_d = 1'b1;
        if (m_wready)  w_done_d  = 1'b1;
        // AW and W handshakes may land in either order or together.
        if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = StB;
      end
      StB: begin
        if (m_bvalid) begin
          rsp_err  = (m_bresp != 2'b00);
          rsp_load = 1'b1;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    if (rsp_load) begin
      if (gnt_q) begin
        rdata1_d = rsp_data;
        err1_d   = rsp_err;
      end else begin
        rdata0_d = rsp_data;
        err0_d   = rsp_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b1;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end

  always_comb begin
    m_awaddr  = addr_q;
    m_awvalid = (state_q == StAw) && !aw_done_q;
    m_wdata   = wdata_q;
    m_wstrb   = wstrb_q;
    m_wvalid  = (state_q == StAw) && !w_done_q;
    m_bready  = (state_q == StB);
    m_araddr  = addr_q;
    m_arvalid = (state_q == StAr);
    m_rready  = (state_q == StR);
    r0_done   = (state_q == StDone) && !gnt_q;
    r1_done   = (state_q == StDone) && gnt_q;
    r0_rdata  = rdata0_q;
    r1_rdata  = rdata1_q;
    r0_err    = err0_q;
    r1_err    = err1_q;
    busy      = (state_q != StIdle);
    grant_id  = gnt_q;
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: random requesters and a random-latency AXI-lite slave,
// checked every cycle against a transaction-level model of arbitration and responses.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic        r0_req, r0_we, r0_done, r0_err, r1_req, r1_we, r1_done, r1_err;
  logic [63:0] r0_addr, r0_wdata, r0_rdata, r1_addr, r1_wdata, r1_rdata;
  logic [7:0]  r0_wstrb, r1_wstrb;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [7:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, busy, grant_id;
  logic [1:0]  m_bresp, m_rresp;

  // Requester-side stimulus
  logic        pend [2];
  logic        f_we [2];
  logic [63:0] f_addr [2];
  logic [63:0] f_wdata [2];
  logic [7:0]  f_wstrb [2];

  assign r0_req = pend[0];
  assign r0_we = f_we[0];
  assign r0_addr = f_addr[0];
  assign r0_wdata = f_wdata[0];
  assign r0_wstrb = f_wstrb[0];
  assign r1_req = pend[1];
  assign r1_we = f_we[1];
  assign r1_addr = f_addr[1];
  assign r1_wdata = f_wdata[1];
  assign r1_wstrb = f_wstrb[1];

  mem_req_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rstn(rstn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_wstrb(r0_wstrb), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_wstrb(r1_wstrb), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .grant_id(grant_id)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [1:0] rnd_resp();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3));
  endfunction

  task automatic new_fields(input int i);
    f_we[i]    = 1'($urandom_range(0, 1));
    f_addr[i]  = rnd64();
    f_wdata[i] = rnd64();
    f_wstrb[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valids"}, {59'd0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check({tag, "_awaddr"}, m_awaddr, 0);
    check({tag, "_araddr"}, m_araddr, 0);
    check({tag, "_wdata"}, m_wdata, 0);
    check({tag, "_wstrb"}, m_wstrb, 0);
    check({tag, "_status"}, {58'd0, r0_done, r0_err, r1_done, r1_err, busy, grant_id}, 0);
    check({tag, "_r0_rdata"}, r0_rdata, 0);
    check({tag, "_r1_rdata"}, r1_rdata, 0);
  endtask

  // Transaction-level reference state
  logic        ptr_m, gid_m, active, done_due, cur, cur_we, win;
  logic        ar_left, aw_left, w_left, resp_left, pa, paw, pw;
  logic [63:0] cur_addr, cur_wdata;
  logic [7:0]  cur_wstrb;
  logic [63:0] exp_rd [2];
  logic        exp_er [2];
  int          busy_cnt;
  bit          rst_done;

  task automatic model_reset();
    ptr_m = 1'b1; gid_m = 1'b0; active = 1'b0; done_due = 1'b0; cur = 1'b0; cur_we = 1'b0;
    ar_left = 1'b0; aw_left = 1'b0; w_left = 1'b0; resp_left = 1'b0; busy_cnt = 0;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
  endtask

  initial begin
    new_fields(0);
    new_fields(1);
    model_reset();
    rst_done = 1'b0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;
    // Both request from reset: r0 must win the first tie.
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (!rst_done && cyc > 2000 && m_rready) begin
        rstn = 1'b0;
        #1;
        check_reset("midop_reset");
        model_reset();
        rst_done = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        new_fields(1);
        pend[1] = 1'b1;
        continue;
      end

      if (!active && (m_arvalid || m_awvalid || m_wvalid)) begin
        win = (pend[0] && pend[1]) ? ~ptr_m : pend[1];
        check("grant_had_req", {63'd0, pend[win]}, 1);
        ptr_m = win; gid_m = win; cur = win; active = 1'b1; busy_cnt = 0;
        cur_we = f_we[win]; cur_addr = f_addr[win];
        cur_wdata = f_wdata[win]; cur_wstrb = f_wstrb[win];
        ar_left = !cur_we; aw_left = cur_we; w_left = cur_we; resp_left = 1'b1;
        // Inputs changing after the grant must not reach the bus.
        new_fields(int'(win));
      end

      check("busy", busy, active);
      check("grant_id", grant_id, gid_m);
      check("arvalid", m_arvalid, active && ar_left);
      check("awvalid", m_awvalid, active && aw_left);
      check("wvalid", m_wvalid, active && w_left);
      check("rready", m_rready, active && !cur_we && !ar_left && resp_left);
      check("bready", m_bready, active && cur_we && !aw_left && !w_left && resp_left);
      if (m_arvalid) check("araddr", m_araddr, cur_addr);
      if (m_awvalid) check("awaddr", m_awaddr, cur_addr);
      if (m_wvalid) begin
        check("wdata", m_wdata, cur_wdata);
        check("wstrb", m_wstrb, cur_wstrb);
      end
      check("r0_done", r0_done, done_due && !cur);
      check("r1_done", r1_done, done_due && cur);
      check("r0_rdata", r0_rdata, exp_rd[0]);
      check("r1_rdata", r1_rdata, exp_rd[1]);
      check("r0_err", r0_err, exp_er[0]);
      check("r1_err", r1_err, exp_er[1]);

      if (active) begin
        busy_cnt++;
        check("stall", {63'd0, busy_cnt > 64}, 0);
        if (busy_cnt > 64) break;
      end

      if (done_due) begin
        done_due = 1'b0;
        active = 1'b0;
        if ($urandom_range(0, 2) != 0) new_fields(int'(cur));
        else pend[cur] = 1'b0;
      end

      // Slave side: random readies, responses only once the request handshakes are done.
      pa = ar_left; paw = aw_left; pw = w_left;
      m_arready = 1'($urandom_range(0, 1));
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
      if (m_arvalid && m_arready) ar_left = 1'b0;
      if (m_awvalid && m_awready) aw_left = 1'b0;
      if (m_wvalid && m_wready) w_left = 1'b0;
      m_rvalid = 1'b0; m_bvalid = 1'b0;
      m_rdata = rnd64(); m_rresp = rnd_resp(); m_bresp = rnd_resp();
      if (active && resp_left && !cur_we && !pa && m_rready && $urandom_range(0, 1) == 1) begin
        m_rvalid = 1'b1;
        exp_rd[cur] = m_rdata;
        exp_er[cur] = (m_rresp != 2'b00);
        resp_left = 1'b0;
        done_due = 1'b1;
      end
      if (active && resp_left && cur_we && !paw && !pw && m_bready &&
          $urandom_range(0, 1) == 1) begin
        m_bvalid = 1'b1;
        exp_rd[cur] = '0;
        exp_er[cur] = (m_bresp != 2'b00);
        resp_left = 1'b0;
        done_due = 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          new_fields(i);
          if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
        end
      end
    end
    check("midop_reset_reached", {63'd0, rst_done}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
